// File: rtl/pwm_cmp8.sv
// PWM comparator fed by an asynchronous ripple counter: synchronizes and deglitches
// the count, compares it against a double-buffered duty value and flags wrap-around.
module pwm_cmp8 #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  input  logic             pol,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] cnt_q,
  output logic             pwm_out,
  output logic             wrap_pulse,
  output logic             irq,
  output logic             ovr
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic             pend_q, pend_d;
  logic             pwm_q, pwm_d;
  logic             wrap_q, wrap_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] sample;
  logic             accept;
  logic             wrap;

  // A sample is trusted only once the value entering the last stage matches it,
  // so a single-cycle ripple glitch can never be accepted.
  assign sample = sync_q[SYNC_STAGES-1];
  assign accept = (sample == sync_q[SYNC_STAGES-2]);
  assign wrap   = (state_q == RUN) && enable && accept && (sample < cnt_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_act_d  = duty_act_q;
    duty_pend_d = duty_pend_q;
    pend_d      = pend_q;
    irq_d       = irq_q;
    ovr_d       = ovr_q;
    wrap_d      = wrap;

    if (accept) begin
      cnt_d = sample;
    end

    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME:   if (!enable) state_d = IDLE;
               else if (accept) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pwm_d = ((state_q == RUN) && enable) ? ((cnt_q < duty_act_q) ^ pol) : pol;

    // The wrap consumes the old pending duty before a same-cycle load refills it.
    if (wrap && pend_q) begin
      duty_act_d = duty_pend_q;
      pend_d     = 1'b0;
    end
    if (duty_load) begin
      duty_pend_d = duty_in;
      pend_d      = 1'b1;
    end

    if (irq_ack) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (wrap) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cnt_q       <= '0;
      duty_act_q  <= '0;
      duty_pend_q <= '0;
      pend_q      <= 1'b0;
      pwm_q       <= 1'b0;
      wrap_q      <= 1'b0;
      irq_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q[0]   <= cnt;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      cnt_q       <= cnt_d;
      duty_act_q  <= duty_act_d;
      duty_pend_q <= duty_pend_d;
      pend_q      <= pend_d;
      pwm_q       <= pwm_d;
      wrap_q      <= wrap_d;
      irq_q       <= irq_d;
      ovr_q       <= ovr_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign wrap_pulse = wrap_q;
  assign irq        = irq_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_pwm_cmp8.sv
// Directed-vector bench for pwm_cmp8: sampling latency, glitch rejection, wrap/irq
// handshake, double-buffered duty, polarity/idle behaviour and asynchronous reset.
module tb_pwm_cmp8;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] cnt;
  logic [7:0] duty_in;
  logic       duty_load;
  logic       pol;
  logic       irq_ack;
  logic [7:0] cnt_q;
  logic       pwm_out;
  logic       wrap_pulse;
  logic       irq;
  logic       ovr;

  int         checks;
  int         failures;
  int         pulses;
  logic [7:0] seenCnt;
  logic       seenPwm;
  logic [7:0] sweepVal;
  logic [7:0] dutyModel;
  logic       sawZero;

  pwm_cmp8 #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cnt        (cnt),
    .duty_in    (duty_in),
    .duty_load  (duty_load),
    .pol        (pol),
    .irq_ack    (irq_ack),
    .cnt_q      (cnt_q),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .irq        (irq),
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge, tallying wrap pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    pulses += int'(wrap_pulse);
  endtask

  task automatic loadDuty(input logic [7:0] v);
    duty_in   = v;
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
  endtask

  // Hold cnt at v long enough to be accepted (3 edges) plus one edge for pwm_out.
  // Optional load/ack strobes land in the cycle where the sample is accepted.
  task automatic applyStimulus(input logic [7:0] v, input logic doLoad,
                               input logic [7:0] loadVal, input logic doAck);
    cnt    = v;
    pulses = 0;
    tick();
    tick();
    if (doLoad) begin
      duty_in   = loadVal;
      duty_load = 1'b1;
    end
    irq_ack = doAck;
    tick();
    seenCnt   = cnt_q;
    duty_load = 1'b0;
    irq_ack   = 1'b0;
    tick();
    seenPwm = pwm_out;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pulses    = 0;
    reset     = 1'b1;
    enable    = 1'b1;
    cnt       = 8'h37;
    duty_in   = 8'h00;
    duty_load = 1'b0;
    pol       = 1'b0;
    irq_ack   = 1'b0;
    dutyModel = 8'h00;
    sawZero   = 1'b0;

    // Reset state and sampling latency
    tick();
    tick();
    checkOutput("rst_cnt_q", 16'(cnt_q), 16'h0);
    checkOutput("rst_pwm", 16'(pwm_out), 16'h0);
    checkOutput("rst_wrap", 16'(wrap_pulse), 16'h0);
    checkOutput("rst_irq", 16'(irq), 16'h0);
    checkOutput("rst_ovr", 16'(ovr), 16'h0);
    reset  = 1'b0;
    pulses = 0;
    tick();
    tick();
    checkOutput("lat_cnt_q_early", 16'(cnt_q), 16'h0);
    tick();
    checkOutput("lat_cnt_q", 16'(cnt_q), 16'h37);
    checkOutput("lat_no_wrap", 16'(pulses), 16'd0);
    checkOutput("lat_irq", 16'(irq), 16'h0);

    // Sweep through a wrap with a pending duty of 0x40
    loadDuty(8'h40);
    for (int i = 'hFE; i <= 'h150; i++) begin
      sweepVal = i[7:0];
      applyStimulus(sweepVal, 1'b0, 8'h00, 1'b0);
      checkOutput("sweep_cnt_q", 16'(seenCnt), 16'(sweepVal));
      checkOutput("sweep_wrap", 16'(pulses), (sweepVal == 8'h00) ? 16'd1 : 16'd0);
      if (sweepVal == 8'h00) dutyModel = 8'h40;
      checkOutput("sweep_pwm", 16'(seenPwm), 16'((sweepVal < dutyModel) ^ pol));
    end
    checkOutput("sweep_irq", 16'(irq), 16'h1);
    checkOutput("sweep_ovr", 16'(ovr), 16'h0);

    // Second wrap while irq still set raises ovr
    applyStimulus(8'h10, 1'b0, 8'h00, 1'b0);
    checkOutput("wrap2_pulse", 16'(pulses), 16'd1);
    checkOutput("wrap2_ovr", 16'(ovr), 16'h1);
    checkOutput("wrap2_pwm", 16'(seenPwm), 16'h1);

    // One-cycle glitch to 0x00 must never reach cnt_q
    pulses = 0;
    cnt    = 8'h00;
    tick();
    cnt = 8'h11;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cnt_q == 8'h00) sawZero = 1'b1;
    end
    checkOutput("glitch_zero_seen", 16'(sawZero), 16'h0);
    checkOutput("glitch_no_wrap", 16'(pulses), 16'd0);
    checkOutput("glitch_cnt_q", 16'(cnt_q), 16'h11);

    // Ack coinciding with a wrap: the set wins
    applyStimulus(8'h05, 1'b0, 8'h00, 1'b1);
    checkOutput("ackwrap_pulse", 16'(pulses), 16'd1);
    checkOutput("ackwrap_irq", 16'(irq), 16'h1);

    // Load in the wrap cycle: old pending value transfers, new one stays pending
    loadDuty(8'h20);
    applyStimulus(8'h06, 1'b0, 8'h00, 1'b0);
    checkOutput("dbuf_nowrap", 16'(pulses), 16'd0);
    applyStimulus(8'h02, 1'b1, 8'h80, 1'b0);
    checkOutput("dbuf_wrap_a", 16'(pulses), 16'd1);
    checkOutput("dbuf_ovr", 16'(ovr), 16'h1);
    applyStimulus(8'h30, 1'b0, 8'h00, 1'b0);
    checkOutput("dbuf_pwm_duty20", 16'(seenPwm), 16'h0);
    applyStimulus(8'h01, 1'b0, 8'h00, 1'b0);
    checkOutput("dbuf_wrap_b", 16'(pulses), 16'd1);
    applyStimulus(8'h70, 1'b0, 8'h00, 1'b0);
    checkOutput("dbuf_pwm_duty80", 16'(seenPwm), 16'h1);

    // Lone ack clears both flags
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("ack_irq", 16'(irq), 16'h0);
    checkOutput("ack_ovr", 16'(ovr), 16'h0);

    // Inverted polarity, then disable mid-period and re-enable below last count
    pol = 1'b1;
    tick();
    checkOutput("pol_pwm_run", 16'(pwm_out), 16'h0);
    enable = 1'b0;
    tick();
    checkOutput("idle_pwm", 16'(pwm_out), 16'h1);
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
    checkOutput("idle_cnt_q", 16'(seenCnt), 16'h08);
    checkOutput("idle_no_wrap", 16'(pulses), 16'd0);
    checkOutput("idle_pwm_hold", 16'(seenPwm), 16'h1);
    enable = 1'b1;
    applyStimulus(8'h03, 1'b0, 8'h00, 1'b0);
    checkOutput("prime_no_wrap", 16'(pulses), 16'd0);
    checkOutput("prime_cnt_q", 16'(seenCnt), 16'h03);
    checkOutput("prime_irq", 16'(irq), 16'h0);
    checkOutput("prime_pwm", 16'(seenPwm), 16'h0);

    // Asynchronous reset mid-operation
    applyStimulus(8'h01, 1'b0, 8'h00, 1'b0);
    checkOutput("pre_rst_irq", 16'(irq), 16'h1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_irq", 16'(irq), 16'h0);
    checkOutput("async_rst_cnt_q", 16'(cnt_q), 16'h0);
    pol = 1'b0;
    cnt = 8'h50;
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(8'h50, 1'b0, 8'h00, 1'b0);
    checkOutput("post_rst_no_wrap", 16'(pulses), 16'd0);
    checkOutput("post_rst_cnt_q", 16'(seenCnt), 16'h50);
    checkOutput("duty0_pwm", 16'(seenPwm), 16'h0);

    // Maximum duty: active everywhere except the top count
    loadDuty(8'hFF);
    applyStimulus(8'h10, 1'b0, 8'h00, 1'b0);
    checkOutput("max_wrap", 16'(pulses), 16'd1);
    checkOutput("max_pwm_10", 16'(seenPwm), 16'h1);
    applyStimulus(8'hFE, 1'b0, 8'h00, 1'b0);
    checkOutput("max_pwm_fe", 16'(seenPwm), 16'h1);
    applyStimulus(8'hFF, 1'b0, 8'h00, 1'b0);
    checkOutput("max_pwm_ff", 16'(seenPwm), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
